decrypt: RTL and testbench

Receive-side counterpart of the crypto datapath stage: it removes the 32-bit repeating-key XOR applied by the transmit stage, restoring the original frames. It sits in the NetFPGA-10G user data path between the input arbiter and the output port lookup, on 256-bit AXI4-Stream. Two software registers supply the key and an enable. Two read-only counters report traffic. Output is fully registered, with a skid buffer so `s_axis_tready` is a flop.

---
 rtl/decrypt_if.sv | 15 +
 rtl/decrypt.sv | 171 +++++++++++++++++
 tb/tb_decrypt.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decrypt_if.sv
// AXI4-Stream bundle for the decrypt stage; master drives the beat, slave drives tready.
interface decrypt_if #(
    parameter int unsigned DataWidth = 256,
    parameter int unsigned UserWidth = 128
) ();
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tstrb;
    logic [UserWidth-1:0]   tuser;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/decrypt.sv
// Receive-side stage that strips the 32-bit repeating-key XOR from each frame.
// Mask is chosen at input acceptance and travels with the beat through the skid buffer.
module decrypt #(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
    parameter int unsigned NUM_RW_REGS          = 2,
    parameter int unsigned NUM_RO_REGS          = 2
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_areset,
    decrypt_if.slave                                      s_axis,
    decrypt_if.master                                     m_axis,
    input  logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]     rw_regs,
    output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]     rw_defaults,
    output logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0]     ro_regs
);
    localparam int unsigned Dw  = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned Uw  = C_M_AXIS_TUSER_WIDTH;
    localparam int unsigned Sdw = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned Suw = C_S_AXIS_TUSER_WIDTH;
    localparam int unsigned Rw  = C_S_AXI_DATA_WIDTH;

    typedef enum logic [1:0] {StHdr1, StHdr2, StPayload} state_e;

    typedef struct packed {
        logic [Dw-1:0]   data;
        logic [Dw/8-1:0] strb;
        logic [Uw-1:0]   user;
        logic            last;
    } beat_t;

    state_e        state_q, state_d;
    logic [Rw-1:0] key_q, key_d;
    logic          enable_q, enable_d;
    logic          s_ready_q, s_ready_d;
    logic [1:0]    cnt_q, cnt_d;
    beat_t         skid0_q, skid0_d, skid1_q, skid1_d;
    beat_t         out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [Rw-1:0] pkt_cnt_q, short_cnt_q;

    logic          accept, out_free, pop, push;
    logic [Dw-1:0] mask;
    beat_t         in_beat;
    logic [Sdw-1:0] in_data;
    logic [Suw-1:0] in_user;
    logic          unused_ctrl;

    assign accept      = s_axis.tvalid & s_ready_q;
    assign in_data     = s_axis.tdata;
    assign in_user     = s_axis.tuser;
    assign unused_ctrl = ^rw_regs[NUM_RW_REGS*Rw-1:Rw+1];

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        enable_d = enable_q;
        mask     = '0;
        case (state_q)
            StHdr2:    mask = {16'h0, {7{key_q}}, key_q[15:0]};
            StPayload: mask = {8{key_q}};
            default:   mask = '0;
        endcase
        // HDR1 carries no mask, so the previous packet's enable never matters there.
        if (!enable_q) mask = '0;
        if (accept) begin
            case (state_q)
                StHdr1: begin
                    key_d    = rw_regs[Rw-1:0];
                    enable_d = rw_regs[Rw];
                    state_d  = s_axis.tlast ? StHdr1 : StHdr2;
                end
                StHdr2:    state_d = s_axis.tlast ? StHdr1 : StPayload;
                StPayload: state_d = s_axis.tlast ? StHdr1 : StPayload;
                default:   state_d = StHdr1;
            endcase
        end
    end

    always_comb begin
        in_beat.data = in_data ^ mask;
        in_beat.strb = s_axis.tstrb;
        in_beat.user = in_user;
        in_beat.last = s_axis.tlast;

        out_free    = !out_valid_q || m_axis.tready;
        pop         = out_free && (cnt_q != 2'd0);
        push        = accept && !(out_free && (cnt_q == 2'd0));
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid0_d     = skid0_q;
        skid1_d     = skid1_q;
        cnt_d       = cnt_q;

        if (out_free) begin
            if (cnt_q != 2'd0) begin
                out_d       = skid0_q;
                out_valid_d = 1'b1;
            end else if (accept) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        case ({pop, push})
            2'b10: begin
                skid0_d = skid1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd0) skid0_d = in_beat;
                else               skid1_d = in_beat;
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    skid0_d = in_beat;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = in_beat;
                end
            end
            default: ;
        endcase

        s_ready_d = (cnt_d < 2'd2);
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q     <= StHdr1;
            key_q       <= '1;
            enable_q    <= 1'b1;
            s_ready_q   <= 1'b0;
            cnt_q       <= 2'd0;
            skid0_q     <= '0;
            skid1_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            pkt_cnt_q   <= '0;
            short_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            enable_q    <= enable_d;
            s_ready_q   <= s_ready_d;
            cnt_q       <= cnt_d;
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            if (out_valid_q && m_axis.tready && out_q.last) pkt_cnt_q <= pkt_cnt_q + 1'b1;
            if (accept && (state_q == StHdr1) && s_axis.tlast) short_cnt_q <= short_cnt_q + 1'b1;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tstrb  = out_q.strb;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tlast  = out_q.last;

    assign rw_defaults = {{(NUM_RW_REGS*Rw-Rw-1){1'b0}}, 1'b1, {Rw{1'b1}}};
    assign ro_regs     = {{(NUM_RO_REGS*Rw-2*Rw){1'b0}}, short_cnt_q, pkt_cnt_q};
endmodule

// File: tb/tb_decrypt.sv
// Randomized bench for decrypt with a packet-level reference model and scoreboard.
module tb_decrypt;
    localparam int unsigned Dw = 256;
    localparam int unsigned Uw = 128;
    localparam int unsigned Sw = 32;

    typedef struct packed {
        logic [Dw-1:0] data;
        logic [Sw-1:0] strb;
        logic [Uw-1:0] user;
        logic          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rw_regs, rw_defaults, ro_regs;
    int          ready_pct = 100;

    decrypt_if #(.DataWidth(Dw), .UserWidth(Uw)) s_axis ();
    decrypt_if #(.DataWidth(Dw), .UserWidth(Uw)) m_axis ();

    decrypt dut (
        .axi_aclk    (clk),
        .axi_areset  (rst),
        .s_axis      (s_axis),
        .m_axis      (m_axis),
        .rw_regs     (rw_regs),
        .rw_defaults (rw_defaults),
        .ro_regs     (ro_regs)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    beat_t       exp_q[$];
    beat_t       out_log[$];
    int unsigned pkts_model = 0;
    int unsigned short_model = 0;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] ref_mask(input int idx, input logic [31:0] key, input logic en);
        if (!en || idx == 0) return '0;
        if (idx == 1) return {16'h0, {7{key}}, key[15:0]};
        return {8{key}};
    endfunction

    function automatic beat_t rand_beat(input logic last);
        beat_t b;
        for (int k = 0; k < 8; k++) b.data[k*32 +: 32] = $urandom;
        b.strb = $urandom;
        for (int k = 0; k < 4; k++) b.user[k*32 +: 32] = $urandom;
        b.last = last;
        return b;
    endfunction

    function automatic beat_t cur_out();
        return {m_axis.tdata, m_axis.tstrb, m_axis.tuser, m_axis.tlast};
    endfunction

    always @(posedge clk) begin
        #1 m_axis.tready = ($urandom_range(0, 99) < ready_pct);
    end

    // Scoreboard: outputs drain first, then the pending input beat is modelled.
    int          m_idx = 0;
    int          rst_age = 0;
    logic [31:0] m_key;
    logic        m_en;
    logic        held = 1'b0;
    beat_t       held_beat;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_idx = 0;
            rst_age = 0;
            held = 1'b0;
            pkts_model = 0;
            short_model = 0;
        end else begin
            beat_t b;
            int    n;
            rst_age++;
            n = exp_q.size();
            if (rst_age > 1)
                check_eq("s_tready", 512'(s_axis.tready), 512'((n - int'(m_axis.tvalid)) < 2));
            if (held) begin
                check_eq("stall_valid", 512'(m_axis.tvalid), 512'(1));
                check_eq("stall_beat", 512'(cur_out()), 512'(held_beat));
            end
            held = m_axis.tvalid && !m_axis.tready;
            held_beat = cur_out();
            if (m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 512'(cur_out()), 512'(0));
                end else begin
                    check_eq("beat", 512'(cur_out()), 512'(exp_q.pop_front()));
                    out_log.push_back(cur_out());
                    if (m_axis.tlast) pkts_model++;
                end
            end
            if (s_axis.tvalid && s_axis.tready) begin
                b = {s_axis.tdata, s_axis.tstrb, s_axis.tuser, s_axis.tlast};
                if (m_idx == 0) begin
                    m_key = rw_regs[31:0];
                    m_en  = rw_regs[32];
                    if (b.last) short_model++;
                end
                b.data = b.data ^ ref_mask(m_idx, m_key, m_en);
                exp_q.push_back(b);
                m_idx = b.last ? 0 : m_idx + 1;
            end
        end
    end

    task automatic send_beat(input beat_t b);
        int   n = 0;
        logic hs = 1'b0;
        {s_axis.tdata, s_axis.tstrb, s_axis.tuser, s_axis.tlast} = b;
        s_axis.tvalid = 1'b1;
        while (!hs) begin
            @(negedge clk);
            hs = s_axis.tready;
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) begin
                check_eq("send_timeout", 512'(0), 512'(1));
                break;
            end
        end
        s_axis.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input beat_t beats[$], input int gap_pct);
        foreach (beats[i]) begin
            send_beat(beats[i]);
            while ($urandom_range(0, 99) < gap_pct) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain", 512'(exp_q.size()), 512'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic beat_t log_back(input int k);
        return out_log[out_log.size() - k];
    endfunction

    initial begin
        beat_t       pkt[$];
        beat_t       orig[$];
        beat_t       b;
        logic [31:0] s0;
        int          len;

        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tstrb  = '0;
        s_axis.tuser  = '0;
        s_axis.tlast  = 1'b0;
        rw_regs       = {32'h1, 32'hFFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_tready", 512'(s_axis.tready), 512'(0));
        check_eq("rst_m_tvalid", 512'(m_axis.tvalid), 512'(0));
        check_eq("rst_m_beat", 512'(cur_out()), 512'(0));
        check_eq("rst_ro_regs", 512'(ro_regs), 512'(0));
        check_eq("rw_defaults", 512'(rw_defaults), 512'({32'h1, 32'hFFFF_FFFF}));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("release_s_tready", 512'(s_axis.tready), 512'(1));

        // All-zero 3-beat packet with the default key, one beat per cycle.
        s_axis.tvalid = 1'b1;
        s_axis.tstrb  = '1;
        @(posedge clk);
        #1;
        check_eq("t1_valid1", 512'(m_axis.tvalid), 512'(1));
        check_eq("t1_beat1", 512'(m_axis.tdata), 512'(0));
        @(posedge clk);
        #1;
        check_eq("t1_beat2", 512'(m_axis.tdata), 512'({16'h0, {240{1'b1}}}));
        s_axis.tlast = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t1_beat3", 512'(m_axis.tdata), 512'({256{1'b1}}));
        check_eq("t1_last", 512'(m_axis.tlast), 512'(1));
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t1_pkt_cnt", 512'(ro_regs[31:0]), 512'(1));

        // Single-beat packet passes untouched and bumps short_cnt.
        s0 = ro_regs[63:32];
        b = rand_beat(1'b1);
        b.data = {8{32'hDEAD_BEEF}};
        send_beat(b);
        drain();
        check_eq("short_data", 512'(log_back(1).data), 512'({8{32'hDEAD_BEEF}}));
        check_eq("short_cnt", 512'(ro_regs[63:32]), 512'(s0 + 32'd1));

        // Enable off: every beat unmodified.
        rw_regs = {32'h0, 32'h1357_9BDF};
        orig.delete();
        for (int i = 0; i < 3; i++) orig.push_back(rand_beat(i == 2));
        send_pkt(orig, 0);
        drain();
        for (int i = 0; i < 3; i++)
            check_eq("enable0", 512'(log_back(3 - i)), 512'(orig[i]));

        // Key rewritten during beat 3 only affects the next packet.
        rw_regs = {32'h1, 32'hA5A5_A5A5};
        orig.delete();
        for (int i = 0; i < 4; i++) orig.push_back(rand_beat(i == 3));
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rw_regs[31:0] = 32'h0F0F_0F0F;
            send_beat(orig[i]);
        end
        for (int i = 0; i < 2; i++) orig.push_back(rand_beat(i == 1));
        send_beat(orig[4]);
        send_beat(orig[5]);
        drain();
        check_eq("keychg_beat4", 512'(log_back(3).data), 512'(orig[3].data ^ {8{32'hA5A5_A5A5}}));
        check_eq("keychg_next", 512'(log_back(1).data),
                 512'(orig[5].data ^ {16'h0, {7{32'h0F0F_0F0F}}, 16'h0F0F}));

        // Round trip through a modelled transmit stage.
        rw_regs = {32'h1, 32'h1234_5678};
        orig.delete();
        pkt.delete();
        for (int i = 0; i < 5; i++) begin
            b = rand_beat(i == 4);
            orig.push_back(b);
            b.data = b.data ^ ref_mask(i, 32'h1234_5678, 1'b1);
            pkt.push_back(b);
        end
        send_pkt(pkt, 20);
        drain();
        for (int i = 0; i < 5; i++)
            check_eq("roundtrip", 512'(log_back(5 - i)), 512'(orig[i]));

        // Random backpressure, random keys and enables, 100 packets.
        ready_pct = 30;
        for (int p = 0; p < 100; p++) begin
            rw_regs = {31'h0, 1'($urandom_range(0, 9) != 0), 32'($urandom)};
            len = $urandom_range(1, 6);
            pkt.delete();
            for (int i = 0; i < len; i++) pkt.push_back(rand_beat(i == len - 1));
            send_pkt(pkt, 25);
        end
        ready_pct = 100;
        drain();
        check_eq("pkt_cnt", 512'(ro_regs[31:0]), 512'(pkts_model));
        check_eq("short_cnt_all", 512'(ro_regs[63:32]), 512'(short_model));

        // Reset with beats stuck in the pipeline, then a fresh 2-beat packet.
        ready_pct = 0;
        @(posedge clk);
        #1;
        send_beat(rand_beat(1'b0));
        send_beat(rand_beat(1'b0));
        #3 rst = 1'b1;
        #1;
        check_eq("midrst_m_tvalid", 512'(m_axis.tvalid), 512'(0));
        check_eq("midrst_m_beat", 512'(cur_out()), 512'(0));
        check_eq("midrst_ro_regs", 512'(ro_regs), 512'(0));
        check_eq("midrst_s_tready", 512'(s_axis.tready), 512'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        ready_pct = 100;
        @(posedge clk);
        #1;
        rw_regs = {32'h1, 32'hC0DE_0042};
        orig.delete();
        for (int i = 0; i < 2; i++) orig.push_back(rand_beat(i == 1));
        send_pkt(orig, 0);
        drain();
        check_eq("post_rst_hdr1", 512'(log_back(2).data), 512'(orig[0].data));
        check_eq("post_rst_hdr2", 512'(log_back(1).data),
                 512'(orig[1].data ^ {16'h0, {7{32'hC0DE_0042}}, 16'h0042}));
        check_eq("post_rst_pkt_cnt", 512'(ro_regs[31:0]), 512'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
